// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM loader slice: default geometry,
// the loader state encoding and the size of one complete operand set.
package mvm_pkg;

    localparam int K = 16;
    localparam int B = 8;

    // One run needs the full matrix (row-major) followed by the vector.
    localparam int MVM_WORDS = K * K + K;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        LOAD_A,
        GAP_A,
        LOAD_X,
        GAP_X,
        START,
        WAIT_DONE,
        DRAIN
    } state_t;

endpackage

// File: rtl/mvm_loader_if.sv
// Upstream element stream feeding the loader: a plain valid/ready
// handshake carrying one signed element per transfer.
interface mvm_loader_if #(
    parameter int B = mvm_pkg::B
);
    logic                s_valid;
    logic signed [B-1:0] s_data;
    logic                s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/mvm_stage_buf.sv
// Single-port staging RAM for one operand set. The read port is
// registered and returns zero whenever no read is requested, so its
// output register can drive the MVM data bus directly.
module mvm_stage_buf #(
    parameter int B         = 8,
    parameter int LOG_DEPTH = 9
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [LOG_DEPTH-1:0] addr,
    input  logic signed [B-1:0]  wdata,
    output logic signed [B-1:0]  rdata
);

    logic signed [B-1:0] mem [2**LOG_DEPTH];

    // Write on request; registered read that idles at zero between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/mvm_loader.sv
// Collects K*K matrix words and K vector words from the upstream stream,
// then replays them into the MVM with the loadMatrix/loadVector/start
// pulses, waits for done and holds busy through the K+1 cycle result sweep.
module mvm_loader #(
    parameter int K         = mvm_pkg::K,
    parameter int B         = mvm_pkg::B,
    parameter int LOG_DEPTH = 9
) (
    input  logic                clk,
    input  logic                reset,
    mvm_loader_if.slave         s,
    output logic                load_matrix,
    output logic                load_vector,
    output logic                start,
    output logic signed [B-1:0] data_in,
    input  logic                mvm_done,
    output logic                busy,
    output logic                run_done
);

    import mvm_pkg::*;

    localparam logic [LOG_DEPTH-1:0] FILL_LAST  = LOG_DEPTH'(K * K + K - 1);
    localparam logic [LOG_DEPTH-1:0] A_END      = LOG_DEPTH'(K * K);
    localparam logic [LOG_DEPTH-1:0] X_END      = LOG_DEPTH'(K * K + K);
    localparam logic [LOG_DEPTH-1:0] DRAIN_LAST = LOG_DEPTH'(K);
    localparam logic [LOG_DEPTH-1:0] DRAIN_PRE  = LOG_DEPTH'(K - 1);
    localparam logic [LOG_DEPTH-1:0] ONE        = LOG_DEPTH'(1);

    state_t               state;
    logic [LOG_DEPTH-1:0] fill_cnt;
    logic [LOG_DEPTH-1:0] rd_cnt;
    logic [LOG_DEPTH-1:0] drain_cnt;

    logic                 xfer;
    logic                 buf_we;
    logic                 buf_re;
    logic [LOG_DEPTH-1:0] buf_addr;

    // Buffer control: writes while filling, reads while a load state still
    // has words left; reset suppresses both so data_in clears immediately.
    always_comb begin
        xfer     = s.s_valid && s.s_ready;
        buf_we   = xfer && !reset;
        buf_re   = !reset &&
                   ((state == LOAD_A && rd_cnt != A_END) ||
                    (state == LOAD_X && rd_cnt != X_END));
        buf_addr = (state == IDLE || state == FILL) ? fill_cnt : rd_cnt;
    end

    // The buffer's registered read port is the data_in output register.
    mvm_stage_buf #(
        .B         (B),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .re    (buf_re),
        .addr  (buf_addr),
        .wdata (s.s_data),
        .rdata (data_in)
    );

    // Sequencer: state, counters and all registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            rd_cnt      <= '0;
            drain_cnt   <= '0;
            s.s_ready   <= 1'b0;
            load_matrix <= 1'b0;
            load_vector <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            load_matrix <= 1'b0;
            load_vector <= 1'b0;
            start       <= 1'b0;
            run_done    <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    s.s_ready <= 1'b1;
                    if (xfer) begin
                        fill_cnt <= fill_cnt + ONE;
                        if (fill_cnt == FILL_LAST) begin
                            state       <= LOAD_A;
                            s.s_ready   <= 1'b0;
                            busy        <= 1'b1;
                            load_matrix <= 1'b1;
                            rd_cnt      <= '0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                LOAD_A: begin
                    if (rd_cnt == A_END) begin
                        state <= GAP_A;
                    end else begin
                        rd_cnt <= rd_cnt + ONE;
                    end
                end
                GAP_A: begin
                    state       <= LOAD_X;
                    load_vector <= 1'b1;
                end
                LOAD_X: begin
                    if (rd_cnt == X_END) begin
                        state <= GAP_X;
                    end else begin
                        rd_cnt <= rd_cnt + ONE;
                    end
                end
                GAP_X: begin
                    state <= START;
                    start <= 1'b1;
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mvm_done) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= IDLE;
                        fill_cnt  <= '0;
                        rd_cnt    <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b0;
                        s.s_ready <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + ONE;
                        run_done  <= (drain_cnt == DRAIN_PRE);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_loader.sv
// Bench for mvm_loader: fills operand sets through the stream interface,
// queues the expected per-cycle output tuple, and a negedge monitor
// compares every queued cycle and flags pulses in unqueued cycles.
module tb_mvm_loader;

    localparam int K         = 16;
    localparam int B         = 8;
    localparam int LOG_DEPTH = 9;
    localparam int WORDS     = K * K + K;
    localparam int START_REL = K * K + K + 4;
    localparam int DONE_REL  = START_REL + 40;
    localparam int DRAIN_END = DONE_REL + K + 1;
    localparam int IDLE_REL  = DRAIN_END + 1;

    typedef struct {
        int          cyc;
        logic [13:0] v;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                stub_done = 1'b0;
    logic                tb_done = 1'b0;
    logic                mvm_done;
    logic                load_matrix;
    logic                load_vector;
    logic                start;
    logic signed [B-1:0] data_in;
    logic                busy;
    logic                run_done;

    int                  cyc = 0;
    int                  checks = 0;
    int                  errors = 0;
    logic [7:0]          words [WORDS];
    exp_t                exp_q [$];

    assign mvm_done = stub_done | tb_done;

    mvm_loader_if #(.B(B)) bus ();

    mvm_loader #(
        .K         (K),
        .B         (B),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (bus),
        .load_matrix (load_matrix),
        .load_vector (load_vector),
        .start       (start),
        .data_in     (data_in),
        .mvm_done    (mvm_done),
        .busy        (busy),
        .run_done    (run_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] pack(input logic lm, input logic lv, input logic st,
                                         input logic rd, input logic bz, input logic sr,
                                         input logic [7:0] d);
        return {lm, lv, st, rd, bz, sr, d};
    endfunction

    // Expected tuple r cycles after the first LOAD_A cycle of a full run.
    function automatic logic [13:0] gen(input int r);
        logic [7:0] d;
        d = 8'h00;
        if (r >= 1 && r <= K * K) d = words[r - 1];
        else if (r >= K * K + 3 && r <= K * K + K + 2) d = words[r - 3];
        return pack(r == 0, r == K * K + 2, r == START_REL, r == DRAIN_END,
                    r <= DRAIN_END, r == IDLE_REL, d);
    endfunction

    task automatic push(input int c, input logic [13:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        logic [13:0] act;
        exp_t        e;
        act = {load_matrix, load_vector, start, run_done, busy, bus.s_ready, data_in};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missed_cycle_%0d: expected tuple never sampled", exp_q[0].cyc);
            exp_q.delete(0);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("[TB] FAIL cycle_%0d lm/lv/st/rd/busy/rdy=%b data=%h, expected %b data=%h",
                         cyc, act[13:8], act[7:0], e.v[13:8], e.v[7:0]);
            end
        end else if (load_matrix === 1'b1 || load_vector === 1'b1 ||
                     start === 1'b1 || run_done === 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_pulse cycle_%0d lm/lv/st/rd=%b, expected 0000",
                     cyc, act[13:10]);
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) check_output();

    // Stub MVM: done arrives 40 cycles after each start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (start === 1'b1) begin
                repeat (40) @(posedge clk);
                #1 stub_done = 1'b1;
                @(posedge clk);
                #1 stub_done = 1'b0;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, output int xfer_cyc);
        bit ok;
        int tries;
        ok = 1'b0;
        tries = 0;
        xfer_cyc = -1;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (!ok && tries < 50) begin
            @(negedge clk);
            ok = (bus.s_ready === 1'b1);
            @(posedge clk);
            #1;
            tries++;
        end
        bus.s_valid = 1'b0;
        if (ok) begin
            xfer_cyc = cyc;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: s_ready=%b, expected 1", bus.s_ready);
        end
    endtask

    task automatic drain_queue();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // One fill + replay; abort_rel >= 0 pulses reset that many cycles into LOAD_A.
    task automatic apply_stimulus(input bit toggle, input bit inject, input bit neg,
                                  input int abort_rel);
        int t;
        int xc;
        for (int n = 0; n < WORDS; n++) begin
            words[n] = (n < K * K) ? 8'(n % 128) : 8'd1;
            if (neg) words[n] = ~words[n];
        end
        t = -1;
        for (int n = 0; n < WORDS; n++) begin
            if (inject && n == 100) tb_done = 1'b1;
            send_word(words[n], xc);
            tb_done = 1'b0;
            t = xc;
            if (toggle && n != WORDS - 1) begin
                @(posedge clk);
                #1;
            end
        end
        if (t < 0) t = cyc;
        if (abort_rel < 0) begin
            for (int r = 0; r <= IDLE_REL; r++) push(t + r, gen(r));
            if (inject) begin
                wait_until(t + 265);
                tb_done = 1'b1;
                @(posedge clk);
                #1 tb_done = 1'b0;
            end
        end else begin
            for (int r = 0; r <= abort_rel; r++) push(t + r, gen(r));
            push(t + abort_rel + 1, pack(0, 0, 0, 0, 0, 0, 8'h00));
            push(t + abort_rel + 2, pack(0, 0, 0, 0, 0, 1, 8'h00));
            wait_until(t + abort_rel);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
        end
        drain_queue();
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        push(cyc, pack(0, 0, 0, 0, 0, 0, 8'h00));
        push(cyc + 1, pack(0, 0, 0, 0, 0, 1, 8'h00));
        push(cyc + 2, pack(0, 0, 0, 0, 0, 1, 8'h00));
        drain_queue();

        apply_stimulus(1'b0, 1'b0, 1'b0, -1);
        apply_stimulus(1'b1, 1'b1, 1'b0, -1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 50);
        apply_stimulus(1'b0, 1'b0, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
